// File: rtl/ulpb_layer_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ulpb_layer_ctrl_pkg : shared widths, opcodes and header field positions
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ulpb_layer_ctrl_pkg;

  localparam int ADDR_WIDTH = 8;
  localparam int DATA_WIDTH = 32;

  localparam logic [3:0] LC_OP_WRITE = 4'h0;
  localparam logic [3:0] LC_OP_READ  = 4'h1;

  localparam int LC_HDR_OP_LSB    = 28;
  localparam int LC_HDR_IDX_LSB   = 24;
  localparam int LC_HDR_CNT_LSB   = 16;
  localparam int LC_HDR_PRIO_BIT  = 15;
  localparam int LC_HDR_REPLY_LSB = 0;

  // Header fields kept for the lifetime of a message.
  typedef struct packed {
    logic [3:0]            op;
    logic [7:0]            cnt;
    logic                  prio;
    logic [ADDR_WIDTH-1:0] reply;
  } lc_hdr_t;

endpackage

`default_nettype wire

// File: rtl/ulpb_layer_ctrl_if.sv
// ---------------------------------------------------------------------------
// ulpb_layer_ctrl_if : ULPB node TX/RX handshake pins seen by the layer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface ulpb_layer_ctrl_if;
  import ulpb_layer_ctrl_pkg::*;

  logic [ADDR_WIDTH-1:0] RX_ADDR;
  logic [DATA_WIDTH-1:0] RX_DATA;
  logic                  RX_REQ;
  logic                  RX_PEND;
  logic                  RX_FAIL;
  logic                  RX_ACK;
  logic [ADDR_WIDTH-1:0] TX_ADDR;
  logic [DATA_WIDTH-1:0] TX_DATA;
  logic                  TX_REQ;
  logic                  TX_PEND;
  logic                  PRIORITY;
  logic                  TX_ACK;
  logic                  TX_SUCC;
  logic                  TX_FAIL;
  logic                  TX_RESP_ACK;

  // Node side
  modport master (
    output RX_ADDR, RX_DATA, RX_REQ, RX_PEND, RX_FAIL, TX_ACK, TX_SUCC, TX_FAIL,
    input  RX_ACK, TX_ADDR, TX_DATA, TX_REQ, TX_PEND, PRIORITY, TX_RESP_ACK
  );

  // Layer controller side
  modport slave (
    input  RX_ADDR, RX_DATA, RX_REQ, RX_PEND, RX_FAIL, TX_ACK, TX_SUCC, TX_FAIL,
    output RX_ACK, TX_ADDR, TX_DATA, TX_REQ, TX_PEND, PRIORITY, TX_RESP_ACK
  );

endinterface

`default_nettype wire

// File: rtl/ulpb_lc_regfile.sv
// ---------------------------------------------------------------------------
// ulpb_lc_regfile : 2^IDX_W x 32 register file, one write port, comb read
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ulpb_lc_regfile
  import ulpb_layer_ctrl_pkg::*;
#(
  parameter int IDX_W = 3
) (
  input  wire logic                               clk,
  input  wire logic                               rst_n,
  input  wire logic                               we,
  input  wire logic [IDX_W-1:0]                   wr_idx,
  input  wire logic [DATA_WIDTH-1:0]              wr_data,
  input  wire logic [IDX_W-1:0]                   rd_idx,
  output logic      [DATA_WIDTH-1:0]              rd_data,
  output logic      [DATA_WIDTH*(2**IDX_W)-1:0]   regs_flat
);

  localparam int NREG = 2 ** IDX_W;

  logic [DATA_WIDTH-1:0] r_mem [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_mem[i] <= '0;
      end
    end else if (we) begin
      r_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = r_mem[rd_idx];

  generate
    for (genvar g = 0; g < NREG; g++) begin : g_flat
      assign regs_flat[g*DATA_WIDTH +: DATA_WIDTH] = r_mem[g];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/ulpb_layer_ctrl.sv
// ---------------------------------------------------------------------------
// ulpb_layer_ctrl : decodes ULPB messages into register writes, answers reads
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ulpb_layer_ctrl
  import ulpb_layer_ctrl_pkg::*;
#(
  parameter int IDX_W = 3
) (
  input  wire logic                             CLKIN,
  input  wire logic                             RESETn,
  ulpb_layer_ctrl_if.slave                      bus,
  output logic [DATA_WIDTH*(2**IDX_W)-1:0]      REG_OUT,
  output logic                                  REG_WR,
  output logic [IDX_W-1:0]                      REG_WR_IDX
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RX_HDR   = 3'd1,
    S_RX_WR    = 3'd2,
    S_RX_DRAIN = 3'd3,
    S_TX_WORD  = 3'd4,
    S_TX_WAIT  = 3'd5,
    S_TX_RESP  = 3'd6
  } state_t;

  state_t                r_state,    w_state;
  lc_hdr_t               r_hdr,      w_hdr;
  logic [IDX_W-1:0]      r_idx,      w_idx;
  logic                  r_last,     w_last;
  logic                  r_rx_ack,   w_rx_ack;
  logic                  r_tx_req,   w_tx_req;
  logic [ADDR_WIDTH-1:0] r_tx_addr,  w_tx_addr;
  logic [DATA_WIDTH-1:0] r_tx_data,  w_tx_data;
  logic                  r_tx_pend,  w_tx_pend;
  logic                  r_tx_prio,  w_tx_prio;
  logic                  r_resp_ack, w_resp_ack;
  logic                  r_reg_wr,   w_reg_wr;
  logic [IDX_W-1:0]      r_wr_idx,   w_wr_idx;
  logic                  w_we;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic                  w_unused;

  assign w_unused = ^bus.RX_ADDR;

  ulpb_lc_regfile #(.IDX_W(IDX_W)) u_regfile (
    .clk       (CLKIN),
    .rst_n     (RESETn),
    .we        (w_we),
    .wr_idx    (r_idx),
    .wr_data   (bus.RX_DATA),
    .rd_idx    (r_idx),
    .rd_data   (w_rdata),
    .regs_flat (REG_OUT)
  );

  always_comb begin
    w_state    = r_state;
    w_hdr      = r_hdr;
    w_idx      = r_idx;
    w_last     = r_last;
    w_rx_ack   = r_rx_ack;
    w_tx_req   = r_tx_req;
    w_tx_addr  = r_tx_addr;
    w_tx_data  = r_tx_data;
    w_tx_pend  = r_tx_pend;
    w_tx_prio  = r_tx_prio;
    w_resp_ack = r_resp_ack;
    w_reg_wr   = 1'b0;
    w_wr_idx   = r_wr_idx;
    w_we       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.RX_REQ && !bus.RX_FAIL) begin
          w_rx_ack    = 1'b1;
          w_hdr.op    = bus.RX_DATA[LC_HDR_OP_LSB +: 4];
          w_hdr.cnt   = bus.RX_DATA[LC_HDR_CNT_LSB +: 8];
          w_hdr.prio  = bus.RX_DATA[LC_HDR_PRIO_BIT];
          w_hdr.reply = bus.RX_DATA[LC_HDR_REPLY_LSB +: ADDR_WIDTH];
          w_idx       = bus.RX_DATA[LC_HDR_IDX_LSB +: IDX_W];
          w_last      = !bus.RX_PEND;
          w_state     = S_RX_HDR;
        end
      end

      S_RX_HDR, S_RX_WR, S_RX_DRAIN: begin
        if (bus.RX_FAIL) begin
          w_rx_ack = 1'b0;
          w_state  = S_IDLE;
        end else if (r_rx_ack && !bus.RX_REQ) begin
          w_rx_ack = 1'b0;
          if (r_last) begin
            w_state = (r_hdr.op == LC_OP_READ) ? S_TX_WORD : S_IDLE;
          end else if (r_state == S_RX_HDR) begin
            w_state = (r_hdr.op == LC_OP_WRITE) ? S_RX_WR : S_RX_DRAIN;
          end
        end else if (!r_rx_ack && bus.RX_REQ && (r_state != S_RX_HDR)) begin
          w_rx_ack = 1'b1;
          w_last   = !bus.RX_PEND;
          if (r_state == S_RX_WR) begin
            w_we     = 1'b1;
            w_reg_wr = 1'b1;
            w_wr_idx = r_idx;
            w_idx    = r_idx + 1'b1;
          end
        end
      end

      S_TX_WORD: begin
        if (bus.TX_FAIL) begin
          w_tx_req   = 1'b0;
          w_resp_ack = 1'b1;
          w_state    = S_TX_RESP;
        end else if (!r_tx_req) begin
          // Data is fetched at load time so late writes are reflected.
          w_tx_req  = 1'b1;
          w_tx_addr = r_hdr.reply;
          w_tx_data = w_rdata;
          w_tx_pend = (r_hdr.cnt != 8'd0);
          w_tx_prio = r_hdr.prio;
          w_idx     = r_idx + 1'b1;
          if (r_hdr.cnt != 8'd0) begin
            w_hdr.cnt = r_hdr.cnt - 8'd1;
          end
        end else if (bus.TX_ACK) begin
          w_tx_req = 1'b0;
          w_state  = S_TX_WAIT;
        end
      end

      S_TX_WAIT: begin
        if (bus.TX_SUCC || bus.TX_FAIL) begin
          w_resp_ack = 1'b1;
          w_state    = S_TX_RESP;
        end else if (!bus.TX_ACK && r_tx_pend) begin
          w_state = S_TX_WORD;
        end
      end

      S_TX_RESP: begin
        if (!bus.TX_SUCC && !bus.TX_FAIL) begin
          w_resp_ack = 1'b0;
          w_tx_prio  = 1'b0;
          w_state    = S_IDLE;
        end
      end

      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLKIN or negedge RESETn) begin
    if (!RESETn) begin
      r_state    <= S_IDLE;
      r_hdr      <= '0;
      r_idx      <= '0;
      r_last     <= 1'b0;
      r_rx_ack   <= 1'b0;
      r_tx_req   <= 1'b0;
      r_tx_addr  <= '0;
      r_tx_data  <= '0;
      r_tx_pend  <= 1'b0;
      r_tx_prio  <= 1'b0;
      r_resp_ack <= 1'b0;
      r_reg_wr   <= 1'b0;
      r_wr_idx   <= '0;
    end else begin
      r_state    <= w_state;
      r_hdr      <= w_hdr;
      r_idx      <= w_idx;
      r_last     <= w_last;
      r_rx_ack   <= w_rx_ack;
      r_tx_req   <= w_tx_req;
      r_tx_addr  <= w_tx_addr;
      r_tx_data  <= w_tx_data;
      r_tx_pend  <= w_tx_pend;
      r_tx_prio  <= w_tx_prio;
      r_resp_ack <= w_resp_ack;
      r_reg_wr   <= w_reg_wr;
      r_wr_idx   <= w_wr_idx;
    end
  end

  assign bus.RX_ACK      = r_rx_ack;
  assign bus.TX_REQ      = r_tx_req;
  assign bus.TX_ADDR     = r_tx_addr;
  assign bus.TX_DATA     = r_tx_data;
  assign bus.TX_PEND     = r_tx_pend;
  assign bus.PRIORITY    = r_tx_prio;
  assign bus.TX_RESP_ACK = r_resp_ack;
  assign REG_WR          = r_reg_wr;
  assign REG_WR_IDX      = r_wr_idx;

endmodule

`default_nettype wire

// File: tb/tb_ulpb_layer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ulpb_layer_ctrl : directed + randomized bench against a register model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_ulpb_layer_ctrl;
  import ulpb_layer_ctrl_pkg::*;

  localparam int IDX_W = 3;
  localparam int NREG  = 1 << IDX_W;

  logic                       CLKIN  = 1'b0;
  logic                       RESETn = 1'b0;
  logic [DATA_WIDTH*NREG-1:0] REG_OUT;
  logic                       REG_WR;
  logic [IDX_W-1:0]           REG_WR_IDX;

  ulpb_layer_ctrl_if bus();

  ulpb_layer_ctrl #(.IDX_W(IDX_W)) dut (
    .CLKIN      (CLKIN),
    .RESETn     (RESETn),
    .bus        (bus),
    .REG_OUT    (REG_OUT),
    .REG_WR     (REG_WR),
    .REG_WR_IDX (REG_WR_IDX)
  );

  always #5 CLKIN = ~CLKIN;

  int               checks    = 0;
  int               failures  = 0;
  int               wr_pulses = 0;
  int               tx_rises  = 0;
  logic [IDX_W-1:0] last_wr_idx = '0;
  logic             prev_tx_req = 1'b0;
  logic [31:0]      model [NREG];

  always @(negedge CLKIN) begin
    if (REG_WR === 1'b1) begin
      wr_pulses++;
      last_wr_idx = REG_WR_IDX;
    end
    if (bus.TX_REQ === 1'b1 && !prev_tx_req) tx_rises++;
    prev_tx_req = (bus.TX_REQ === 1'b1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int w);
    case (w)
      0:       return bus.RX_ACK;
      1:       return bus.TX_REQ;
      default: return bus.TX_RESP_ACK;
    endcase
  endfunction

  task automatic wait_for(input string tag, input int w, input logic v);
    int n = 0;
    while (sig(w) !== v && n < 200) begin
      @(negedge CLKIN);
      n++;
    end
    chk(tag, {31'd0, sig(w)}, {31'd0, v});
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < NREG; i++)
      chk($sformatf("%s_reg%0d", tag, i), REG_OUT[i*32 +: 32], model[i]);
  endtask

  task automatic rx_word(input logic [31:0] d, input logic pend);
    bus.RX_DATA = d;
    bus.RX_PEND = pend;
    bus.RX_REQ  = 1'b1;
    @(negedge CLKIN);
    chk("rx_ack_rise", {31'd0, bus.RX_ACK}, 32'd1);
    bus.RX_REQ = 1'b0;
    wait_for("rx_ack_fall", 0, 1'b0);
  endtask

  task automatic wr_msg(input int start, input int n, input logic [31:0] d [8]);
    int base = wr_pulses;
    rx_word({LC_OP_WRITE, 4'(start), 8'(n - 1), 1'b0, 7'h0, 8'h00}, 1'b1);
    for (int k = 0; k < n; k++) begin
      rx_word(d[k], k != n - 1);
      model[(start + k) % NREG] = d[k];
    end
    repeat (2) @(negedge CLKIN);
    chk("wr_pulse_count", wr_pulses - base, n);
    check_regs("wr");
  endtask

  task automatic rd_msg(input int start, input int cnt1, input logic [7:0] reply,
                        input logic prio, input int extra, input int fail_after);
    int base = tx_rises;
    int nsend;
    rx_word({LC_OP_READ, 4'(start), 8'(cnt1), prio, 7'h0, reply}, extra > 0);
    for (int e = 0; e < extra; e++) rx_word($urandom, e != extra - 1);
    @(negedge CLKIN);
    chk("tx_req_latency", {31'd0, bus.TX_REQ}, 32'd1);
    nsend = (fail_after > 0 && fail_after <= cnt1) ? fail_after : cnt1 + 1;
    for (int k = 0; k < nsend; k++) begin
      if (k > 0) wait_for("tx_req_rise", 1, 1'b1);
      chk("tx_addr", {24'd0, bus.TX_ADDR}, {24'd0, reply});
      chk("tx_data", bus.TX_DATA, model[(start + k) % NREG]);
      chk("tx_pend", {31'd0, bus.TX_PEND}, {31'd0, k != cnt1});
      chk("priority", {31'd0, bus.PRIORITY}, {31'd0, prio});
      bus.TX_ACK = 1'b1;
      wait_for("tx_req_drop", 1, 1'b0);
      bus.TX_ACK = 1'b0;
    end
    if (nsend == cnt1 + 1) bus.TX_SUCC = 1'b1;
    else                   bus.TX_FAIL = 1'b1;
    wait_for("tx_resp_ack_rise", 2, 1'b1);
    bus.TX_SUCC = 1'b0;
    bus.TX_FAIL = 1'b0;
    wait_for("tx_resp_ack_fall", 2, 1'b0);
    repeat (6) @(negedge CLKIN);
    chk("tx_word_count", tx_rises - base, nsend);
    chk("tx_req_idle", {31'd0, bus.TX_REQ}, 32'd0);
  endtask

  initial begin
    logic [31:0] d [8];
    int base_wr, base_tx;

    bus.RX_ADDR = '0; bus.RX_DATA = '0; bus.RX_REQ = 1'b0; bus.RX_PEND = 1'b0;
    bus.RX_FAIL = 1'b0; bus.TX_ACK = 1'b0; bus.TX_SUCC = 1'b0; bus.TX_FAIL = 1'b0;
    for (int i = 0; i < NREG; i++) model[i] = '0;

    repeat (3) @(negedge CLKIN);
    chk("rst_rx_ack",   {31'd0, bus.RX_ACK},      32'd0);
    chk("rst_tx_req",   {31'd0, bus.TX_REQ},      32'd0);
    chk("rst_tx_data",  bus.TX_DATA,              32'd0);
    chk("rst_tx_addr",  {24'd0, bus.TX_ADDR},     32'd0);
    chk("rst_priority", {31'd0, bus.PRIORITY},    32'd0);
    chk("rst_resp_ack", {31'd0, bus.TX_RESP_ACK}, 32'd0);
    chk("rst_reg_wr",   {31'd0, REG_WR},          32'd0);
    check_regs("rst");
    RESETn = 1'b1;
    @(negedge CLKIN);

    // Single-register write
    d[0] = 32'hDEADBEEF;
    wr_msg(2, 1, d);
    chk("single_wr_idx", {29'd0, last_wr_idx}, 32'd2);

    // Wrapping burst
    d[0] = 32'd1; d[1] = 32'd2; d[2] = 32'd3; d[3] = 32'd4;
    wr_msg(6, 4, d);

    // Randomized write bursts
    for (int t = 0; t < 4; t++) begin
      for (int k = 0; k < 8; k++) d[k] = $urandom;
      wr_msg($urandom_range(0, NREG - 1), $urandom_range(1, 6), d);
    end

    // Directed read with wrap and priority
    rd_msg(7, 1, 8'h5A, 1'b1, 0, 0);

    // Randomized reads, some with discarded trailing words
    for (int t = 0; t < 4; t++)
      rd_msg($urandom_range(0, NREG - 1), $urandom_range(0, 3), 8'($urandom),
             1'($urandom), $urandom_range(0, 2), 0);

    // TX_FAIL after the first of three reply words
    rd_msg(3, 2, 8'hC3, 1'b0, 0, 1);

    // RX_FAIL on the third word of a WRITE at 0
    base_wr = wr_pulses;
    rx_word({LC_OP_WRITE, 4'd0, 8'd3, 1'b0, 7'h0, 8'h00}, 1'b1);
    rx_word(32'hA5A5_0000, 1'b1);
    rx_word(32'hA5A5_0001, 1'b1);
    bus.RX_DATA = 32'hA5A5_0002; bus.RX_PEND = 1'b1;
    bus.RX_REQ  = 1'b1;          bus.RX_FAIL = 1'b1;
    repeat (2) @(negedge CLKIN);
    chk("rx_fail_ack", {31'd0, bus.RX_ACK}, 32'd0);
    bus.RX_REQ = 1'b0; bus.RX_FAIL = 1'b0;
    model[0] = 32'hA5A5_0000; model[1] = 32'hA5A5_0001;
    repeat (2) @(negedge CLKIN);
    chk("rx_fail_wr_count", wr_pulses - base_wr, 2);
    check_regs("rx_fail");
    d[0] = 32'h1234_5678;
    wr_msg(5, 1, d);

    // Unknown opcode with three trailing words
    base_wr = wr_pulses;
    base_tx = tx_rises;
    rx_word({4'hF, 4'd1, 8'd2, 1'b1, 7'h0, 8'h33}, 1'b1);
    for (int k = 0; k < 3; k++) rx_word($urandom, k != 2);
    repeat (8) @(negedge CLKIN);
    chk("unk_wr_count", wr_pulses - base_wr, 0);
    chk("unk_tx_count", tx_rises - base_tx, 0);
    check_regs("unk");

    // Reset in the middle of a message
    rx_word({LC_OP_WRITE, 4'd4, 8'd1, 1'b0, 7'h0, 8'h00}, 1'b1);
    bus.RX_DATA = 32'hFEED_F00D; bus.RX_PEND = 1'b1; bus.RX_REQ = 1'b1;
    @(negedge CLKIN);
    RESETn = 1'b0;
    #1;
    chk("midrst_rx_ack", {31'd0, bus.RX_ACK}, 32'd0);
    for (int i = 0; i < NREG; i++) model[i] = '0;
    check_regs("midrst");
    bus.RX_REQ = 1'b0;
    @(negedge CLKIN);
    RESETn = 1'b1;
    @(negedge CLKIN);
    d[0] = 32'hCAFE_0001; d[1] = 32'hCAFE_0002;
    wr_msg(7, 2, d);
    rd_msg(7, 1, 8'h11, 1'b0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
